// File: rtl/drum_pkg.sv
// Shared types and constants for the drum strike detector slice.
package drum_pkg;

    localparam int unsigned CLK_HZ          = 3_000_000;
    // 50 ms refractory lockout expressed in clk cycles
    localparam int unsigned REFRACT_DEFAULT = CLK_HZ / 20;
    localparam int unsigned GYRO_W          = 16;
    localparam int unsigned QUAT_W          = 16;
    localparam int unsigned VEL_W           = 8;
    localparam int unsigned ZONE_W          = 2;

    typedef enum logic [1:0] {ST_IDLE, ST_SWING, ST_REFRACT} strike_state_t;
    typedef enum logic [1:0] {ZONE_LEFT, ZONE_CENTRE, ZONE_RIGHT} drum_zone_t;

    // Downward swing speed = -gyro_y, clamped so -32768 maps to 32767
    function automatic logic signed [GYRO_W-1:0] sat_speed(input logic signed [GYRO_W-1:0] gy);
        if (gy == {1'b1, {(GYRO_W-1){1'b0}}}) begin
            return {1'b0, {(GYRO_W-1){1'b1}}};
        end
        return GYRO_W'(-gy);
    endfunction

endpackage

// File: rtl/drum_strike_detector_if.sv
// Sensor-in / strike-out bundle between the IMU controller, detector and SPI packet path.
interface drum_strike_detector_if;
    import drum_pkg::*;

    logic                      gyro_valid;
    logic signed [GYRO_W-1:0]  gyro_x;
    logic signed [GYRO_W-1:0]  gyro_y;
    logic signed [GYRO_W-1:0]  gyro_z;
    logic                      quat_valid;
    logic signed [QUAT_W-1:0]  quat_z;
    logic                      strike_valid;
    logic [VEL_W-1:0]          strike_velocity;
    logic [ZONE_W-1:0]         strike_zone;
    logic                      armed;

    modport master (
        output gyro_valid, gyro_x, gyro_y, gyro_z, quat_valid, quat_z,
        input  strike_valid, strike_velocity, strike_zone, armed
    );

    modport slave (
        input  gyro_valid, gyro_x, gyro_y, gyro_z, quat_valid, quat_z,
        output strike_valid, strike_velocity, strike_zone, armed
    );

endinterface

// File: rtl/drum_strike_detector_zone_classifier.sv
// Holds the latest quat_z and grades it into left/centre/right drum zones.
module strike_zone_classifier
    import drum_pkg::*;
#(
    parameter logic signed [QUAT_W-1:0] ZONE_THRESH = 16'sd4096
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     quat_valid,
    input  logic signed [QUAT_W-1:0] quat_z,
    output logic [ZONE_W-1:0]        zone_c
);

    localparam logic signed [QUAT_W-1:0] NEG_THRESH = QUAT_W'(-ZONE_THRESH);

    logic signed [QUAT_W-1:0] qz_q;
    logic signed [QUAT_W-1:0] qz_c;

    // Latch the most recent quaternion z component
    always_ff @(posedge clk) begin
        if (rst) begin
            qz_q <= '0;
        end else if (quat_valid) begin
            qz_q <= quat_z;
        end
    end

    // A quat sample arriving with the release sample takes precedence over the latch
    always_comb begin
        qz_c   = quat_valid ? quat_z : qz_q;
        zone_c = ZONE_W'(ZONE_CENTRE);
        if (qz_c < NEG_THRESH) begin
            zone_c = ZONE_W'(ZONE_LEFT);
        end else if (qz_c > ZONE_THRESH) begin
            zone_c = ZONE_W'(ZONE_RIGHT);
        end
    end

endmodule

// File: rtl/drum_strike_detector.sv
// Drum strike detector: arms on a fast downward swing, fires one graded strike on release.
// Optional feature macro: STRIKE_ZONE_EN (zone classification from quat_z).
module drum_strike_detector
    import drum_pkg::*;
#(
    parameter logic signed [GYRO_W-1:0] ARM_THRESH        = 16'sd2000,
    parameter logic signed [GYRO_W-1:0] RELEASE_THRESH    = 16'sd300,
    parameter int unsigned              VEL_SHIFT         = 6,
    parameter int unsigned              REFRACT_CYCLES    = REFRACT_DEFAULT,
    parameter int unsigned              MAX_SWING_SAMPLES = 200,
    parameter logic signed [QUAT_W-1:0] ZONE_THRESH       = 16'sd4096
) (
    input  logic                   clk,
    input  logic                   rst,
    drum_strike_detector_if.slave  bus
);

    localparam int unsigned RC_W = $clog2(REFRACT_CYCLES);
    localparam int unsigned SC_W = $clog2(MAX_SWING_SAMPLES + 1);

    strike_state_t            state_q, state_d;
    logic signed [GYRO_W-1:0] peak_q, peak_d;
    logic [SC_W-1:0]          swing_cnt_q, swing_cnt_d;
    logic [RC_W-1:0]          refract_q, refract_d;
    logic signed [GYRO_W-1:0] speed_c;
    logic [GYRO_W-1:0]        peak_shift_c;
    logic [VEL_W-1:0]         vel_c;
    logic                     strike_d;
    logic [ZONE_W-1:0]        zone_q;

    // Velocity grade from the pre-release peak, clamped to 8 bits
    always_comb begin
        peak_shift_c = GYRO_W'(peak_q) >> VEL_SHIFT;
        vel_c        = (peak_shift_c > GYRO_W'(255)) ? 8'd255 : VEL_W'(peak_shift_c);
    end

    // Next-state logic: swing arming, peak tracking, release, abandon and lockout
    always_comb begin
        state_d     = state_q;
        peak_d      = peak_q;
        swing_cnt_d = swing_cnt_q;
        refract_d   = refract_q;
        strike_d    = 1'b0;
        speed_c     = sat_speed(bus.gyro_y);
        case (state_q)
            ST_IDLE: begin
                if (bus.gyro_valid && (speed_c >= ARM_THRESH)) begin
                    state_d     = ST_SWING;
                    peak_d      = speed_c;
                    swing_cnt_d = SC_W'(1);
                end
            end
            ST_SWING: begin
                if (bus.gyro_valid) begin
                    if (speed_c <= RELEASE_THRESH) begin
                        strike_d    = 1'b1;
                        state_d     = ST_REFRACT;
                        refract_d   = RC_W'(REFRACT_CYCLES - 1);
                        peak_d      = '0;
                        swing_cnt_d = '0;
                    end else if (swing_cnt_q == SC_W'(MAX_SWING_SAMPLES - 1)) begin
                        // this sample exhausts the swing window
                        state_d     = ST_IDLE;
                        peak_d      = '0;
                        swing_cnt_d = '0;
                    end else begin
                        if (speed_c > peak_q) begin
                            peak_d = speed_c;
                        end
                        swing_cnt_d = swing_cnt_q + SC_W'(1);
                    end
                end
            end
            ST_REFRACT: begin
                if (refract_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    refract_d = refract_q - RC_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, datapath and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q             <= ST_IDLE;
            peak_q              <= '0;
            swing_cnt_q         <= '0;
            refract_q           <= '0;
            bus.strike_valid    <= 1'b0;
            bus.strike_velocity <= '0;
            bus.armed           <= 1'b0;
        end else begin
            state_q          <= state_d;
            peak_q           <= peak_d;
            swing_cnt_q      <= swing_cnt_d;
            refract_q        <= refract_d;
            bus.strike_valid <= strike_d;
            bus.armed        <= (state_d == ST_SWING);
            if (strike_d) begin
                bus.strike_velocity <= vel_c;
            end
        end
    end

`ifdef STRIKE_ZONE_EN
    logic [ZONE_W-1:0] zone_c;
    logic              unused_in;

    assign unused_in = ^{bus.gyro_x, bus.gyro_z};

    strike_zone_classifier #(
        .ZONE_THRESH (ZONE_THRESH)
    ) u_zone (
        .clk        (clk),
        .rst        (rst),
        .quat_valid (bus.quat_valid),
        .quat_z     (bus.quat_z),
        .zone_c     (zone_c)
    );

    // Capture the zone alongside each strike
    always_ff @(posedge clk) begin
        if (rst) begin
            zone_q <= '0;
        end else if (strike_d) begin
            zone_q <= zone_c;
        end
    end
`else
    logic unused_in;

    assign unused_in = ^{bus.gyro_x, bus.gyro_z, bus.quat_valid, bus.quat_z, ZONE_THRESH};

    // Without zone sensing every strike reports the centre zone
    always_ff @(posedge clk) begin
        if (rst) begin
            zone_q <= '0;
        end else begin
            zone_q <= ZONE_W'(ZONE_CENTRE);
        end
    end
`endif

    assign bus.strike_zone = zone_q;

endmodule

// File: tb/tb_drum_strike_detector.sv
// Directed self-checking bench for drum_strike_detector (short refractory window).
module tb_drum_strike_detector;
    import drum_pkg::*;

    localparam int unsigned N_REF = 40;

`ifdef STRIKE_ZONE_EN
    localparam int unsigned Z_RST  = 0;
    localparam int unsigned Z_LEFT = 0;
    localparam int unsigned Z_CEN  = 1;
    localparam int unsigned Z_RGT  = 2;
`else
    localparam int unsigned Z_RST  = 1;
    localparam int unsigned Z_LEFT = 1;
    localparam int unsigned Z_CEN  = 1;
    localparam int unsigned Z_RGT  = 1;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   passes = 0;
    int   fails  = 0;

    drum_strike_detector_if bus ();

    drum_strike_detector #(
        .REFRACT_CYCLES (N_REF)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One gyro sample; called at a negedge, returns at the next negedge
    task automatic gy(input logic signed [15:0] y);
        bus.gyro_valid = 1'b1;
        bus.gyro_y     = y;
        @(negedge clk);
        bus.gyro_valid = 1'b0;
    endtask

    task automatic qz(input logic signed [15:0] z);
        bus.quat_valid = 1'b1;
        bus.quat_z     = z;
        @(negedge clk);
        bus.quat_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic expect_strike(input string tag, input int vel, input int zone);
        check({tag, "_valid"}, 32'(bus.strike_valid), 32'd1);
        check({tag, "_vel"}, 32'(bus.strike_velocity), 32'(vel));
        check({tag, "_zone"}, 32'(bus.strike_zone), 32'(zone));
        check({tag, "_armed"}, 32'(bus.armed), 32'd0);
        idle(1);
        check({tag, "_pulse1"}, 32'(bus.strike_valid), 32'd0);
    endtask

    initial begin
        bus.gyro_valid = 1'b0;
        bus.gyro_x     = 16'sd123;
        bus.gyro_y     = '0;
        bus.gyro_z     = -16'sd77;
        bus.quat_valid = 1'b0;
        bus.quat_z     = '0;

        // reset values
        idle(3);
        check("rst_valid", 32'(bus.strike_valid), 32'd0);
        check("rst_vel", 32'(bus.strike_velocity), 32'd0);
        check("rst_zone", 32'(bus.strike_zone), 32'd0);
        check("rst_armed", 32'(bus.armed), 32'd0);
        rst = 1'b0;
        idle(1);
        check("post_rst_zone", 32'(bus.strike_zone), 32'(Z_RST));

        // basic swing, back-to-back samples, peak 6400 -> 100
        gy(-16'sd3000);
        check("arm", 32'(bus.armed), 32'd1);
        gy(-16'sd6400);
        gy(-16'sd4000);
        check("swing_no_strike", 32'(bus.strike_valid), 32'd0);
        gy(-16'sd200);
        expect_strike("s1", 100, Z_CEN);

        // swing inside lockout is ignored
        gy(-16'sd3000);
        check("refract_armed", 32'(bus.armed), 32'd0);
        gy(-16'sd6400);
        gy(-16'sd200);
        check("refract_strike", 32'(bus.strike_valid), 32'd0);
        check("refract_vel_held", 32'(bus.strike_velocity), 32'd100);

        // same swing after lockout
        idle(N_REF + 5);
        gy(-16'sd3000);
        gy(-16'sd6400);
        gy(-16'sd200);
        expect_strike("s2", 100, Z_CEN);

        // saturating negation, velocity clamp
        idle(N_REF + 5);
        gy(-16'sd32768);
        check("sat_arm", 32'(bus.armed), 32'd1);
        gy(-16'sd100);
        expect_strike("sat", 255, Z_CEN);

        // just below arm threshold
        idle(N_REF + 5);
        repeat (5) gy(-16'sd1999);
        check("below_arm", 32'(bus.armed), 32'd0);
        gy(-16'sd100);
        check("below_no_strike", 32'(bus.strike_valid), 32'd0);

        // swing window exhausted
        repeat (199) gy(-16'sd5000);
        check("long_armed", 32'(bus.armed), 32'd1);
        gy(-16'sd5000);
        check("abandon_armed", 32'(bus.armed), 32'd0);
        gy(-16'sd100);
        check("abandon_no_strike", 32'(bus.strike_valid), 32'd0);
        check("abandon_vel_held", 32'(bus.strike_velocity), 32'd255);

        // reset mid-swing
        gy(-16'sd3000);
        gy(-16'sd6400);
        check("pre_rst_armed", 32'(bus.armed), 32'd1);
        rst = 1'b1;
        idle(1);
        check("midrst_armed", 32'(bus.armed), 32'd0);
        check("midrst_vel", 32'(bus.strike_velocity), 32'd0);
        rst = 1'b0;
        gy(-16'sd200);
        check("midrst_no_strike", 32'(bus.strike_valid), 32'd0);
        check("midrst_zone", 32'(bus.strike_zone), 32'(Z_RST));

        // zone grading from latched quat_z
        qz(-16'sd5000);
        gy(-16'sd3000);
        gy(-16'sd6400);
        gy(-16'sd200);
        expect_strike("zl", 100, Z_LEFT);
        idle(N_REF + 5);
        qz(16'sd0);
        gy(-16'sd3000);
        gy(-16'sd6400);
        gy(-16'sd200);
        expect_strike("zc", 100, Z_CEN);
        idle(N_REF + 5);
        qz(16'sd5000);
        gy(-16'sd3000);
        gy(-16'sd6400);
        gy(-16'sd200);
        expect_strike("zr", 100, Z_RGT);

        // quat sample coincident with the release sample wins over the latch
        idle(N_REF + 5);
        qz(-16'sd5000);
        gy(-16'sd3000);
        gy(-16'sd6400);
        bus.quat_valid = 1'b1;
        bus.quat_z     = 16'sd5000;
        bus.gyro_valid = 1'b1;
        bus.gyro_y     = -16'sd200;
        @(negedge clk);
        bus.quat_valid = 1'b0;
        bus.gyro_valid = 1'b0;
        expect_strike("zcoinc", 100, Z_RGT);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
